// File: rtl/mod20_pkg.sv
// Shared definitions for the mod-20 count-stream monitor: modulus, widths,
// tracking states, blank digit codes and the expected-next-value rule.
package mod20_pkg;

  localparam int unsigned MOD   = 20;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    FAULT
  } state_t;

  // Digit codes shown when the sampled count is outside 0..MOD
  localparam logic [1:0] BLANK_TENS = 2'b11;
  localparam logic [3:0] BLANK_ONES = 4'hF;

  // Value the counter must present after prev when stepping in direction dir
  function automatic logic [CNT_W-1:0] next_exp(input logic [CNT_W-1:0] prev,
                                                input logic             dir);
    if (!dir)
      return (prev == CNT_W'(MOD)) ? CNT_W'(1) : prev + CNT_W'(1);
    else
      return (prev == '0) ? CNT_W'(MOD - 1) : prev - CNT_W'(1);
  endfunction

endpackage

// File: rtl/mod20_monitor_if.sv
// Count stream from the lab counter: value, direction and new-step strobe.
interface mod20_monitor_if;
  import mod20_pkg::*;

  logic [CNT_W-1:0] cnt_in;
  logic             dir;
  logic             cnt_vld;

  modport master (output cnt_in, output dir, output cnt_vld);
  modport slave  (input  cnt_in, input  dir, input  cnt_vld);
endinterface

// File: rtl/mod20_bcd.sv
// Combinational count to tens/ones converter; values above MOD show blank.
module mod20_bcd
  import mod20_pkg::*;
(
  input  logic [CNT_W-1:0] cnt,
  output logic [1:0]       tens,
  output logic [3:0]       ones
);

  // Table lookup over the legal range keeps the conversion free of dividers
  always_comb begin
    tens = BLANK_TENS;
    ones = BLANK_ONES;
    for (int unsigned i = 0; i <= MOD; i++) begin
      if (cnt == CNT_W'(i)) begin
        tens = 2'(i / 10);
        ones = 4'(i % 10);
      end
    end
  end

endmodule

// File: rtl/mod20_monitor.sv
// Receive-side checker for the mod-20 up/down count stream. Verifies each
// step, flags wrap events, keeps a signed wrap tally and drives BCD digits.
// Optional: define MOD20_MON_HOLD_EN to accept cnt==prev as a legal hold.
module mod20_monitor
  import mod20_pkg::*;
#(
  parameter int unsigned WRAP_W = 8,
  parameter int unsigned RESYNC = 2
) (
  input  logic              clk,
  input  logic              Reset_n,
  mod20_monitor_if.slave    sif,
  input  logic              err_clr,
  output logic [1:0]        bcd_tens,
  output logic [3:0]        bcd_ones,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              step_err,
  output logic [3:0]        err_cnt,
  output logic              locked
);

  localparam int unsigned GOOD_W = (RESYNC > 1) ? $clog2(RESYNC) : 1;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    prev, prev_nxt, exp_cnt;
  logic [GOOD_W-1:0]   good_cnt, good_nxt;
  logic [1:0]          tens_nxt, conv_tens;
  logic [3:0]          ones_nxt, conv_ones;
  logic                wrap_up_nxt, wrap_dn_nxt;
  logic [WRAP_W-1:0]   wrap_cnt_nxt;
  logic                step_err_nxt;
  logic [3:0]          err_cnt_nxt;
  logic                in_range, match, hold, up_wrap, dn_wrap, err_hit;

  mod20_bcd u_bcd (
    .cnt  (sif.cnt_in),
    .tens (conv_tens),
    .ones (conv_ones)
  );

  assign in_range = (sif.cnt_in <= CNT_W'(MOD));
  assign exp_cnt  = next_exp(prev, sif.dir);
  assign match    = (sif.cnt_in == exp_cnt);
  assign up_wrap  = !sif.dir && (prev == CNT_W'(MOD)) && (sif.cnt_in == CNT_W'(1));
  assign dn_wrap  = sif.dir && (prev == '0) && (sif.cnt_in == CNT_W'(MOD - 1));
`ifdef MOD20_MON_HOLD_EN
  assign hold     = (sif.cnt_in == prev);
`else
  assign hold     = 1'b0;
`endif
  assign locked   = (state == TRACK);

  // Next-state, step checking, wrap and error bookkeeping
  always_comb begin
    state_nxt    = state;
    prev_nxt     = prev;
    good_nxt     = good_cnt;
    tens_nxt     = bcd_tens;
    ones_nxt     = bcd_ones;
    wrap_up_nxt  = 1'b0;
    wrap_dn_nxt  = 1'b0;
    wrap_cnt_nxt = wrap_cnt;
    step_err_nxt = step_err;
    err_cnt_nxt  = err_cnt;
    err_hit      = 1'b0;

    if (sif.cnt_vld) begin
      tens_nxt = conv_tens;
      ones_nxt = conv_ones;
      if (in_range)
        prev_nxt = sif.cnt_in;

      unique case (state)
        IDLE: begin
          if (in_range) state_nxt = TRACK;
          else          err_hit   = 1'b1;
        end
        TRACK: begin
          if (match) begin
            if (up_wrap) begin
              wrap_up_nxt  = 1'b1;
              wrap_cnt_nxt = wrap_cnt + WRAP_W'(1);
            end
            if (dn_wrap) begin
              wrap_dn_nxt  = 1'b1;
              wrap_cnt_nxt = wrap_cnt - WRAP_W'(1);
            end
          end else if (!hold) begin
            err_hit   = 1'b1;
            state_nxt = FAULT;
            good_nxt  = '0;
          end
        end
        FAULT: begin
          if (match) begin
            if (good_cnt == GOOD_W'(RESYNC - 1)) begin
              state_nxt = TRACK;
              good_nxt  = '0;
            end else begin
              good_nxt  = good_cnt + GOOD_W'(1);
            end
          end else if (!hold) begin
            err_hit  = 1'b1;
            good_nxt = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // A new error outranks a simultaneous clear and restarts the count at 1
    if (err_hit) begin
      step_err_nxt = 1'b1;
      err_cnt_nxt  = err_clr ? 4'd1 : ((err_cnt == 4'hF) ? 4'hF : err_cnt + 4'd1);
    end else if (err_clr) begin
      step_err_nxt = 1'b0;
      err_cnt_nxt  = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      prev     <= '0;
      good_cnt <= '0;
      bcd_tens <= '0;
      bcd_ones <= '0;
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
      wrap_cnt <= '0;
      step_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      prev     <= prev_nxt;
      good_cnt <= good_nxt;
      bcd_tens <= tens_nxt;
      bcd_ones <= ones_nxt;
      wrap_up  <= wrap_up_nxt;
      wrap_dn  <= wrap_dn_nxt;
      wrap_cnt <= wrap_cnt_nxt;
      step_err <= step_err_nxt;
      err_cnt  <= err_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mod20_monitor.sv
// Bench for mod20_monitor: directed vector table, long wrap run and
// randomized stream, all checked against a behavioural reference model.
module tb_mod20_monitor;
  import mod20_pkg::*;

`ifdef MOD20_MON_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       err_clr = 1'b0;
  logic [1:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       wrap_up, wrap_dn, step_err, locked;
  logic [7:0] wrap_cnt;
  logic [3:0] err_cnt;

  mod20_monitor_if sif ();

  mod20_monitor #(.WRAP_W(8), .RESYNC(2)) dut (
    .clk      (clk),
    .Reset_n  (Reset_n),
    .sif      (sif),
    .err_clr  (err_clr),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .wrap_up  (wrap_up),
    .wrap_dn  (wrap_dn),
    .wrap_cnt (wrap_cnt),
    .step_err (step_err),
    .err_cnt  (err_cnt),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: mode 0 = waiting for first sample, 1 = tracking,
  // 2 = recovering after an error
  int       m_mode, m_prev, m_good, m_tens, m_ones, m_wu, m_wd, m_serr, m_ecnt;
  int       wraps_seen;
  logic [7:0] m_wc;

  typedef struct {
    bit rst; bit vld; int cnt; bit dir; bit clr;
    int tens; int ones; int wu; int wd; int wc; int serr; int ecnt; int lock;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void add(bit rst, bit vld, int cnt, bit dir, bit clr,
                              int tens, int ones, int wu, int wd, int wc,
                              int serr, int ecnt, int lock);
    vec_t v;
    v.rst = rst; v.vld = vld; v.cnt = cnt; v.dir = dir; v.clr = clr;
    v.tens = tens; v.ones = ones; v.wu = wu; v.wd = wd; v.wc = wc;
    v.serr = serr; v.ecnt = ecnt; v.lock = lock;
    tbl.push_back(v);
  endfunction

  function automatic int model_exp(bit d);
    return d ? (m_prev + MOD - 1) % MOD : (m_prev % MOD) + 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_good = 0; m_tens = 0; m_ones = 0;
    m_wu = 0; m_wd = 0; m_wc = '0; m_serr = 0; m_ecnt = 0;
  endtask

  task automatic model_step(input bit vld, input int c, input bit d, input bit clr);
    bit err, inr, hold;
    int e;
    err = 1'b0;
    m_wu = 0;
    m_wd = 0;
    if (vld) begin
      inr  = (c <= MOD);
      e    = model_exp(d);
      hold = HOLD && inr && (c == m_prev);
      if (inr) begin m_tens = c / 10; m_ones = c % 10; end
      else     begin m_tens = 3;      m_ones = 15;     end
      if (m_mode == 0) begin
        if (inr) m_mode = 1; else err = 1'b1;
      end else if (m_mode == 1) begin
        if (c == e) begin
          if (!d && m_prev == MOD && c == 1) begin m_wu = 1; m_wc = m_wc + 8'd1; wraps_seen++; end
          if (d && m_prev == 0 && c == MOD - 1) begin m_wd = 1; m_wc = m_wc - 8'd1; end
        end else if (!hold) begin
          err = 1'b1; m_mode = 2; m_good = 0;
        end
      end else begin
        if (c == e) begin
          m_good++;
          if (m_good == 2) begin m_mode = 1; m_good = 0; end
        end else if (!hold) begin
          err = 1'b1; m_good = 0;
        end
      end
      if (inr) m_prev = c;
    end
    if (err) begin
      m_serr = 1;
      m_ecnt = clr ? 1 : ((m_ecnt < 15) ? m_ecnt + 1 : 15);
    end else if (clr) begin
      m_serr = 0;
      m_ecnt = 0;
    end
  endtask

  task automatic cmp_model();
    chk("m_tens",  int'(bcd_tens), m_tens);
    chk("m_ones",  int'(bcd_ones), m_ones);
    chk("m_wu",    int'(wrap_up),  m_wu);
    chk("m_wd",    int'(wrap_dn),  m_wd);
    chk("m_wc",    int'(wrap_cnt), int'(m_wc));
    chk("m_serr",  int'(step_err), m_serr);
    chk("m_ecnt",  int'(err_cnt),  m_ecnt);
    chk("m_lock",  int'(locked),   (m_mode == 1) ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset_n = 1'b0;
    sif.cnt_vld = 1'b0;
    err_clr = 1'b0;
    #2;
    model_reset();
    cmp_model();
    @(negedge clk);
    Reset_n = 1'b1;
  endtask

  task automatic apply(input bit vld, input int c, input bit d, input bit clr);
    @(negedge clk);
    sif.cnt_vld = vld;
    sif.cnt_in  = 5'(c);
    sif.dir     = d;
    err_clr     = clr;
    @(posedge clk);
    #1;
    model_step(vld, c, d, clr);
    sif.cnt_vld = 1'b0;
    err_clr     = 1'b0;
    cmp_model();
  endtask

  task automatic chk_row(input int i, input vec_t v);
    chk($sformatf("row%0d_tens", i), int'(bcd_tens), v.tens);
    chk($sformatf("row%0d_ones", i), int'(bcd_ones), v.ones);
    chk($sformatf("row%0d_wu", i),   int'(wrap_up),  v.wu);
    chk($sformatf("row%0d_wd", i),   int'(wrap_dn),  v.wd);
    chk($sformatf("row%0d_wc", i),   int'(wrap_cnt), v.wc);
    chk($sformatf("row%0d_serr", i), int'(step_err), v.serr);
    chk($sformatf("row%0d_ecnt", i), int'(err_cnt),  v.ecnt);
    chk($sformatf("row%0d_lock", i), int'(locked),   v.lock);
  endtask

  initial begin
    bit run_dir;
    sif.cnt_in  = '0;
    sif.dir     = 1'b0;
    sif.cnt_vld = 1'b0;
    wraps_seen  = 0;
    model_reset();

    // Up stream 0..20 then wrap to 1, then an idle cycle clears the pulse
    add(1,0,0,0,0, 0,0,0,0,0,0,0,0);
    for (int i = 0; i <= 20; i++) add(0,1,i,0,0, i/10,i%10,0,0,0,0,0,1);
    add(0,1,1,0,0, 0,1,1,0,1,0,0,1);
    add(0,0,0,0,0, 0,1,0,0,1,0,0,1);
    // Down stream 0,19,18
    add(1,0,0,0,0, 0,0,0,0,0,0,0,0);
    add(0,1,0,1,0, 0,0,0,0,0,0,0,1);
    add(0,1,19,1,0, 1,9,0,1,255,0,0,1);
    add(0,1,18,1,0, 1,8,0,0,255,0,0,1);
    // Skip 5,6,8 then resync on 9,10
    add(1,0,0,0,0, 0,0,0,0,0,0,0,0);
    add(0,1,5,0,0, 0,5,0,0,0,0,0,1);
    add(0,1,6,0,0, 0,6,0,0,0,0,0,1);
    add(0,1,8,0,0, 0,8,0,0,0,1,1,0);
    add(0,1,9,0,0, 0,9,0,0,0,1,1,0);
    add(0,1,10,0,0, 1,0,0,0,0,1,1,1);
    // Out-of-range 25 keeps prev=5, so 6,7 resync
    add(1,0,0,0,0, 0,0,0,0,0,0,0,0);
    add(0,1,4,0,0, 0,4,0,0,0,0,0,1);
    add(0,1,5,0,0, 0,5,0,0,0,0,0,1);
    add(0,1,25,0,0, 3,15,0,0,0,1,1,0);
    add(0,1,6,0,0, 0,6,0,0,0,1,1,0);
    add(0,1,7,0,0, 0,7,0,0,0,1,1,1);
    // Second error, then error+clear together, then clear alone
    add(0,1,3,0,0, 0,3,0,0,0,1,2,0);
    add(0,1,5,0,1, 0,5,0,0,0,1,1,0);
    add(0,0,0,0,1, 0,5,0,0,0,0,0,0);
    // Resync then hold 7,7
    add(0,1,6,0,0, 0,6,0,0,0,0,0,0);
    add(0,1,7,0,0, 0,7,0,0,0,0,0,1);
    if (HOLD) add(0,1,7,0,0, 0,7,0,0,0,0,0,1);
    else      add(0,1,7,0,0, 0,7,0,0,0,1,1,0);
    // Out-of-range while idle saturates err_cnt, then first legal sample locks
    add(1,0,0,0,0, 0,0,0,0,0,0,0,0);
    for (int i = 0; i < 17; i++) add(0,1,31,0,0, 3,15,0,0,0,1,(i + 1 > 15) ? 15 : i + 1,0);
    add(0,1,20,0,0, 2,0,0,0,0,1,15,1);
    add(0,1,1,0,0, 0,1,1,0,1,1,15,1);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      else apply(tbl[i].vld, tbl[i].cnt, tbl[i].dir, tbl[i].clr);
      chk_row(i, tbl[i]);
    end

    // Long clean up-count: 257 wraps roll the 8-bit tally over to 1
    do_reset();
    wraps_seen = 0;
    apply(1'b1, 0, 1'b0, 1'b0);
    for (int n = 0; n < 6000 && wraps_seen < 257; n++)
      apply(1'b1, model_exp(1'b0), 1'b0, 1'b0);
    chk("wrap_rollover", int'(wrap_cnt), 1);

    // Randomized stream: mostly legal steps with jumps, holds, gaps, clears
    do_reset();
    run_dir = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      int c, r;
      bit v, clr;
      if ($urandom_range(0, 299) == 0) do_reset();
      if ($urandom_range(0, 9) == 0) run_dir = ~run_dir;
      v   = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 24) == 0);
      r   = int'($urandom_range(0, 99));
      if (r < 80)      c = model_exp(run_dir);
      else if (r < 86) c = int'($urandom_range(21, 31));
      else if (r < 91) c = m_prev;
      else             c = int'($urandom_range(0, 20));
      apply(v, c, run_dir, clr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
